// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-road intersection controller with pedestrian walk phase
module traffic_light_fsm #(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 6,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_dbg
);

    localparam int MAX_TICKS = (1 << CNT_W) - 1;

    if (GREEN_TICKS < 1 || GREEN_TICKS > MAX_TICKS ||
        YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_TICKS ||
        ALLRED_TICKS < 1 || ALLRED_TICKS > MAX_TICKS ||
        WALK_TICKS < 1 || WALK_TICKS > MAX_TICKS) begin : g_bad_ticks
        $error("traffic_light_fsm: *_TICKS must be in 1..2**CNT_W-1");
    end

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

    // Plain vector so an out-of-range encoding can exist and be recovered from.
    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] last_cnt;
    logic             phase_done;
    logic             enter_walk;

    always_comb begin
        last_cnt   = '0;
        next_state = ALL_RED_B;
        case (state)
            MAIN_GREEN:  begin last_cnt = GREEN_LAST;  next_state = MAIN_YELLOW; end
            MAIN_YELLOW: begin last_cnt = YELLOW_LAST; next_state = ALL_RED_A;   end
            ALL_RED_A:   begin last_cnt = ALLRED_LAST; next_state = SIDE_GREEN;  end
            SIDE_GREEN:  begin last_cnt = GREEN_LAST;  next_state = SIDE_YELLOW; end
            SIDE_YELLOW: begin last_cnt = YELLOW_LAST; next_state = ALL_RED_B;   end
            ALL_RED_B:   begin
                last_cnt   = ALLRED_LAST;
                next_state = ped_pending ? PED_WALK : MAIN_GREEN;
            end
            PED_WALK:    begin last_cnt = WALK_LAST;   next_state = MAIN_GREEN;  end
            default:     begin last_cnt = '0;          next_state = ALL_RED_B;   end
        endcase
    end

    assign phase_done = tick && (tcnt == last_cnt);
    assign enter_walk = phase_done && (state == ALL_RED_B) && ped_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALL_RED_B;
            tcnt        <= '0;
            ped_pending <= 1'b0;
        end else begin
            if (state == 3'd7) begin
                state <= ALL_RED_B;
                tcnt  <= '0;
            end else if (phase_done) begin
                state <= next_state;
                tcnt  <= '0;
            end else if (tick) begin
                tcnt <= tcnt + CNT_W'(1);
            end

            // Clearing on walk entry takes priority over a press in the same cycle.
            if (enter_walk) begin
                ped_pending <= 1'b0;
            end else if (ped_req && state != PED_WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        main_light = 3'b100;
        side_light = 3'b100;
        walk       = 1'b0;
        case (state)
            MAIN_GREEN:  main_light = 3'b001;
            MAIN_YELLOW: main_light = 3'b010;
            SIDE_GREEN:  side_light = 3'b001;
            SIDE_YELLOW: side_light = 3'b010;
            PED_WALK:    walk       = 1'b1;
            default:     ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_dbg;

    int tests = 0;
    int fails = 0;

    traffic_light_fsm #(
        .GREEN_TICKS (3),
        .YELLOW_TICKS(2),
        .ALLRED_TICKS(1),
        .WALK_TICKS  (2),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_pending(ped_pending),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_main(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] s);
        case (s)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Safety monitor: the two roads are never both showing non-red.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (main_light != 3'b100 && side_light != 3'b100) begin
                fails++;
                $display("FAIL safety: main=%b side=%b both non-red", main_light, side_light);
            end
        end
    end

    // One tick pulse followed by three idle clocks; entered and left at a negedge.
    task automatic one_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_state(input string name, input logic [2:0] s);
        tests++;
        if (state_dbg !== s || main_light !== exp_main(s) || side_light !== exp_side(s) ||
            walk !== (s == 3'd6)) begin
            fails++;
            $display("FAIL %s: state=%0d main=%b side=%b walk=%b, expected state=%0d main=%b side=%b walk=%b",
                     name, state_dbg, main_light, side_light, walk,
                     s, exp_main(s), exp_side(s), (s == 3'd6));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick = 1'b1;
        ped_req = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (state_dbg !== 3'd5 || main_light !== 3'b100 || side_light !== 3'b100 ||
            walk !== 1'b0 || ped_pending !== 1'b0) begin
            fails++;
            $display("FAIL reset: state=%0d main=%b side=%b walk=%b pend=%b, expected 5 100 100 0 0",
                     state_dbg, main_light, side_light, walk, ped_pending);
        end
        tick = 1'b0;
        ped_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cycle();
        logic [2:0] seq [13] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                                 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
        for (int i = 0; i < 13; i++) begin
            one_tick();
            check_state($sformatf("cycle_tick%0d", i + 1), seq[i]);
        end
    endtask

    task automatic test_ped_pulse();
        for (int i = 0; i < 6; i++) one_tick();
        check_state("ped_at_side_green", 3'd3);
        tests++;
        if (ped_pending !== 1'b0) begin
            fails++;
            $display("FAIL ped_idle: pend=%b expected 0", ped_pending);
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        tests++;
        if (ped_pending !== 1'b1) begin
            fails++;
            $display("FAIL ped_latch: pend=%b expected 1", ped_pending);
        end
        for (int i = 0; i < 6; i++) one_tick();
        check_state("ped_walk_entry", 3'd6);
        tests++;
        if (ped_pending !== 1'b0) begin
            fails++;
            $display("FAIL ped_clear: pend=%b expected 0", ped_pending);
        end
        one_tick();
        check_state("ped_walk_2nd", 3'd6);
        one_tick();
        check_state("ped_walk_exit", 3'd0);
    endtask

    task automatic test_ped_hold();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        for (int i = 0; i < 12; i++) one_tick();
        check_state("hold_walk_entry", 3'd6);
        ped_req = 1'b1;
        @(negedge clk);
        tests++;
        if (ped_pending !== 1'b0) begin
            fails++;
            $display("FAIL hold_ignored: pend=%b expected 0", ped_pending);
        end
        one_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_state("hold_main_green", 3'd0);
        tests++;
        if (ped_pending !== 1'b0) begin
            fails++;
            $display("FAIL hold_entry_edge: pend=%b expected 0", ped_pending);
        end
        @(negedge clk);
        tests++;
        if (ped_pending !== 1'b1) begin
            fails++;
            $display("FAIL hold_set_in_green: pend=%b expected 1", ped_pending);
        end
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_freeze();
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) one_tick();
        check_state("freeze_start", 3'd1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (state_dbg !== 3'd1 || main_light !== 3'b010 || side_light !== 3'b100) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL freeze: state=%0d main=%b moved during 1000 idle clocks, expected 1 010",
                     state_dbg, main_light);
        end
        one_tick();
        check_state("freeze_release", 3'd2);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) one_tick();
        check_state("arst_side_yellow", 3'd4);
        tests++;
        if (ped_pending !== 1'b1) begin
            fails++;
            $display("FAIL arst_pending_before: pend=%b expected 1", ped_pending);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (main_light !== 3'b100 || side_light !== 3'b100 || ped_pending !== 1'b0 ||
            state_dbg !== 3'd5) begin
            fails++;
            $display("FAIL arst_immediate: main=%b side=%b pend=%b state=%0d, expected 100 100 0 5",
                     main_light, side_light, ped_pending, state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        force dut.state = 3'd7;
        #1 release dut.state;
        tests++;
        if (state_dbg !== 3'd7 || main_light !== 3'b100 || side_light !== 3'b100 || walk !== 1'b0) begin
            fails++;
            $display("FAIL illegal_decode: state=%0d main=%b side=%b walk=%b, expected 7 100 100 0",
                     state_dbg, main_light, side_light, walk);
        end
        @(negedge clk);
        check_state("illegal_recover", 3'd5);
        one_tick();
        check_state("illegal_resume", 3'd0);
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ped_pulse();
        test_ped_hold();
        test_freeze();
        test_async_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
